sad_select: RTL and testbench

Consumes the packed per-row horizontal SAD results produced by the row SAD unit, one row per handshake. It accumulates the five candidate positions (right quarter, right half, full, left half, left quarter) over a block of `ROWS` rows, then selects the minimum-cost candidate. It sits directly downstream of the row SAD unit and feeds the motion-vector decision logic through a valid/ready output.

---
 rtl/sad_select_pkg.sv | 23 ++
 rtl/sad_select_acc_lane.sv | 33 +++
 rtl/sad_select.sv | 134 +++++++++++++
 tb/tb_sad_select.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_select_pkg.sv
// Shared constants and types for the block-SAD candidate selector.
// Candidate numbering matches the field order of the packed row SAD word.
package sad_pkg;

    localparam int SAD_W    = 12;
    localparam int NUM_CAND = 5;

    localparam logic [2:0] CAND_RQ   = 3'd0;
    localparam logic [2:0] CAND_RH   = 3'd1;
    localparam logic [2:0] CAND_FULL = 3'd2;
    localparam logic [2:0] CAND_LH   = 3'd3;
    localparam logic [2:0] CAND_LQ   = 3'd4;

    // Visit order of the compare sequencer; earlier entries win ties.
    localparam logic [2:0] CMP_ORDER [NUM_CAND] = '{CAND_FULL, CAND_RH, CAND_LH, CAND_RQ, CAND_LQ};

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/sad_select_acc_lane.sv
// One saturating SAD accumulator lane with synchronous clear and add enable.
// Clear takes priority over add, so a row arriving with clear is dropped.
module sad_acc_lane #(
    parameter int ACC_W = 15,
    parameter int IN_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [IN_W-1:0]  i_val,
    output logic [ACC_W-1:0] o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    // One guard bit catches the overflow that selects the saturated value.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, i_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/sad_select.sv
// Accumulates five candidate SADs over a block of rows, then walks them in
// priority order to pick the minimum-cost candidate for the MV decision.
module sad_select
    import sad_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int ACC_W = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      sad_valid,
    input  logic [NUM_CAND*SAD_W-1:0] sad,
    output logic                      sad_ready,
    output logic                      best_valid,
    input  logic                      best_ready,
    output logic [ACC_W-1:0]          best_sad,
    output logic [2:0]                best_idx
);

    localparam int CNT_W = $clog2(ROWS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sad_ready;
    logic             r_best_valid;
    logic [CNT_W-1:0] r_row;
    logic [2:0]       r_step;
    logic [ACC_W-1:0] r_best_sad;
    logic [2:0]       r_best_idx;

    logic             w_accept;
    logic             w_last_row;
    logic             w_res_hs;
    logic             w_lane_clr;
    logic             w_last_step;
    logic [2:0]       w_cand_idx;
    logic [ACC_W-1:0] w_cand_acc;
    logic [ACC_W-1:0] w_acc [NUM_CAND];

    assign w_accept    = (r_state == ACCUM) && r_sad_ready && sad_valid;
    assign w_last_row  = w_accept && (r_row == CNT_W'(ROWS - 1));
    assign w_res_hs    = (r_state == DONE) && r_best_valid && best_ready;
    assign w_lane_clr  = clear || w_res_hs;
    assign w_last_step = (r_step == 3'd4);

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_lane
        sad_acc_lane #(
            .ACC_W (ACC_W),
            .IN_W  (SAD_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (w_lane_clr),
            .i_add (w_accept),
            .i_val (sad[k*SAD_W +: SAD_W]),
            .o_acc (w_acc[k])
        );
    end

    always_comb begin
        w_cand_idx = CMP_ORDER[0];
        case (r_step)
            3'd1:    w_cand_idx = CMP_ORDER[1];
            3'd2:    w_cand_idx = CMP_ORDER[2];
            3'd3:    w_cand_idx = CMP_ORDER[3];
            3'd4:    w_cand_idx = CMP_ORDER[4];
            default: w_cand_idx = CMP_ORDER[0];
        endcase
        w_cand_acc = w_acc[0];
        case (w_cand_idx)
            3'd1:    w_cand_acc = w_acc[1];
            3'd2:    w_cand_acc = w_acc[2];
            3'd3:    w_cand_acc = w_acc[3];
            3'd4:    w_cand_acc = w_acc[4];
            default: w_cand_acc = w_acc[0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_last_row)  w_state_nxt = COMPARE;
                COMPARE: if (w_last_step) w_state_nxt = DONE;
                DONE:    if (w_res_hs)    w_state_nxt = ACCUM;
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    // Handshake outputs follow the next state so they are registered yet on time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ACCUM;
            r_sad_ready  <= 1'b0;
            r_best_valid <= 1'b0;
            r_row        <= '0;
            r_step       <= '0;
            r_best_sad   <= '0;
            r_best_idx   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sad_ready  <= (w_state_nxt == ACCUM);
            r_best_valid <= (w_state_nxt == DONE);
            if (clear) begin
                r_row      <= '0;
                r_step     <= '0;
                r_best_sad <= '0;
                r_best_idx <= '0;
            end else begin
                if (w_accept) begin
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end
                if (r_state == COMPARE) begin
                    r_step <= w_last_step ? 3'd0 : r_step + 3'd1;
                    // Strict less-than keeps the earlier candidate on a tie.
                    if ((r_step == 3'd0) || (w_cand_acc < r_best_sad)) begin
                        r_best_sad <= w_cand_acc;
                        r_best_idx <= w_cand_idx;
                    end
                end
            end
        end
    end

    assign sad_ready  = r_sad_ready;
    assign best_valid = r_best_valid;
    assign best_sad   = r_best_sad;
    assign best_idx   = r_best_idx;

endmodule

// File: tb/tb_sad_select.sv
// Directed bench for sad_select: an 8-row instance for the main scenarios and
// a 64-row, 15-bit instance for accumulator saturation.
module tb_sad_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        sad_valid;
    logic [59:0] sad;
    logic        sad_ready;
    logic        best_valid;
    logic        best_ready;
    logic [14:0] best_sad;
    logic [2:0]  best_idx;

    logic        clr64;
    logic        v64;
    logic [59:0] s64;
    logic        rdy64;
    logic        bv64;
    logic        br64;
    logic [14:0] bs64;
    logic [2:0]  bi64;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_timeouts = 0;

    always #5 clk = ~clk;

    sad_select #(.ROWS(8), .ACC_W(15)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sad_valid  (sad_valid),
        .sad        (sad),
        .sad_ready  (sad_ready),
        .best_valid (best_valid),
        .best_ready (best_ready),
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

    sad_select #(.ROWS(64), .ACC_W(15)) u_dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clr64),
        .sad_valid  (v64),
        .sad        (s64),
        .sad_ready  (rdy64),
        .best_valid (bv64),
        .best_ready (br64),
        .best_sad   (bs64),
        .best_idx   (bi64)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [59:0] pack(input int c0, input int c1, input int c2,
                                         input int c3, input int c4);
        return {12'(c4), 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
    endfunction

    // Returns #1 after the accepting edge with sad_valid dropped.
    task automatic push_row(input logic [59:0] w);
        int n;
        n = 0;
        sad = w;
        sad_valid = 1'b1;
        while (!sad_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) n_timeouts++;
        @(posedge clk);
        #1;
        sad_valid = 1'b0;
    endtask

    task automatic push_block(input logic [59:0] w);
        for (int i = 0; i < 8; i++) push_row(w);
    endtask

    task automatic wait_best(output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!best_valid && n < 50);
        if (n >= 50) n_timeouts++;
        cycles = n;
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        best_ready = 1'b1;
        @(posedge clk);
        #1;
        best_ready = 1'b0;
        check({tag, "_ready_after_hs"}, sad_ready, 1);
        check({tag, "_valid_after_hs"}, best_valid, 0);
    endtask

    initial begin
        int lat;
        int unstable;
        rst_n = 1'b0;
        clear = 1'b0;
        sad_valid = 1'b0;
        sad = '0;
        best_ready = 1'b0;
        clr64 = 1'b0;
        v64 = 1'b0;
        s64 = '0;
        br64 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sad_ready", sad_ready, 0);
        check("rst_best_valid", best_valid, 0);
        check("rst_best_sad", best_sad, 0);
        check("rst_best_idx", best_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", sad_ready, 1);

        // Full-pel minimum and result latency.
        push_block(pack(10, 10, 5, 10, 10));
        check("t1_ready_low", sad_ready, 0);
        wait_best(lat);
        check("t1_latency", lat, 6);
        check("t1_sad", best_sad, 40);
        check("t1_idx", best_idx, 2);
        take_result("t1");

        // Tie between right half and left half.
        push_block(pack(200, 100, 200, 100, 200));
        wait_best(lat);
        check("t2_sad", best_sad, 800);
        check("t2_idx", best_idx, 1);
        take_result("t2");

        // Gapped input, junk while invalid, downstream stall in DONE.
        for (int i = 0; i < 8; i++) begin
            push_row(pack(7, 9, 9, 9, 9));
            sad = pack(4000, 4000, 4000, 4000, 4000);
            if (i < 7) repeat ((i % 3) + 1) @(negedge clk);
        end
        wait_best(lat);
        sad_valid = 1'b1;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (best_valid !== 1'b1 || best_sad !== 15'd56 || best_idx !== 3'd0 || sad_ready !== 1'b0)
                unstable++;
        end
        sad_valid = 1'b0;
        check("t4_unstable_cycles", unstable, 0);
        check("t4_sad", best_sad, 56);
        check("t4_idx", best_idx, 0);
        take_result("t4");

        // Abort a partial block; the row presented with clear is dropped too.
        for (int i = 0; i < 3; i++) push_row(pack(0, 0, 0, 0, 4000));
        sad = pack(0, 0, 0, 0, 4000);
        sad_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sad_valid = 1'b0;
        check("t5_ready_after_clear", sad_ready, 1);
        push_block(pack(50, 50, 50, 50, 1));
        wait_best(lat);
        check("t5_sad", best_sad, 8);
        check("t5_idx", best_idx, 4);
        take_result("t5");

        // Asynchronous reset in the middle of COMPARE.
        push_block(pack(30, 30, 30, 30, 30));
        repeat (2) @(negedge clk);
        check("t6_midcmp_best_sad", best_sad, 240);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", sad_ready, 0);
        check("t6_rst_valid", best_valid, 0);
        check("t6_rst_sad", best_sad, 0);
        check("t6_rst_idx", best_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_block(pack(3, 20, 20, 20, 20));
        wait_best(lat);
        check("t6_sad", best_sad, 24);
        check("t6_idx", best_idx, 0);

        // Clear while holding a result.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("t7_clear_valid", best_valid, 0);
        check("t7_clear_sad", best_sad, 0);
        check("t7_clear_idx", best_idx, 0);
        check("t7_clear_ready", sad_ready, 1);

        // Saturation on the 64-row instance: all candidates tie at full scale.
        s64 = pack(4095, 4095, 4095, 4095, 4095);
        for (int i = 0; i < 64; i++) begin
            int n;
            n = 0;
            v64 = 1'b1;
            while (!rdy64 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) n_timeouts++;
            @(posedge clk);
            #1;
        end
        v64 = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bv64 && n < 50);
            if (n >= 50) n_timeouts++;
        end
        check("t3_sat_sad", bs64, 32767);
        check("t3_sat_idx", bi64, 2);
        check("t3_sat_ready", rdy64, 0);

        check("wait_timeouts", n_timeouts, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
